// File: rtl/sig_replay.sv
// -----------------------------------------------------------------------------
// sig_replay
//
// Capture-then-playback buffer for the microphone path. A trigger records a
// burst of mic samples (one per wr strobe) into an internal RAM; play_start
// later streams the stored burst out over a valid/ready interface, optionally
// looping back to the first sample without a bubble.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   trigger     start recording (IDLE only)
//   length      samples to record, latched on trigger; 0 = full depth
//   wr          sample strobe while recording
//   mic_signal  sample to record
//   play_start  start playback (IDLE only, needs a held recording)
//   loop        wrap to sample 0 after the last sample while playing
//   stop        abort any operation, back to IDLE
//   play_ready  downstream accepts play_data
//   play_valid  play_data holds a valid sample
//   play_data   replayed sample
//   rec_done    one-cycle pulse after a recording completes
//   state       IDLE=0, RECORD=1, PRIME=2, PLAY=3
// -----------------------------------------------------------------------------
module sig_replay #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic [ADDRESS_WIDTH-1:0] length,
    input  logic                     wr,
    input  logic [DATA_WIDTH-1:0]    mic_signal,
    input  logic                     play_start,
    input  logic                     loop,
    input  logic                     stop,
    input  logic                     play_ready,
    output logic                     play_valid,
    output logic [DATA_WIDTH-1:0]    play_data,
    output logic                     rec_done,
    output logic [1:0]               state
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDRESS_WIDTH:0]   SLEN_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PRIME  = 2'd2,
        ST_PLAY   = 2'd3
    } state_t;

    state_t                   state_reg,      state_next;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_reg,     rd_ptr_next;
    logic [ADDRESS_WIDTH-1:0] len_reg,        len_next;
    // One bit wider than an address so a full-depth recording is distinct
    // from "nothing held" (zero).
    logic [ADDRESS_WIDTH:0]   stored_len_reg, stored_len_next;
    logic                     rec_done_reg,   rec_done_next;

    logic                     ram_we;
    logic                     ram_rd_en;
    logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0]    rd_data_reg;

    logic [DATA_WIDTH-1:0]    ram [0:DEPTH-1];

    logic [ADDRESS_WIDTH-1:0] len_m1;
    logic [ADDRESS_WIDTH:0]   full_len;
    logic                     rec_last;
    logic                     play_last;

    // Latched length minus one wraps, so length 0 ends at the all-ones address.
    assign len_m1    = len_reg - ADDR_ONE;
    assign full_len  = (len_reg == '0) ? {1'b1, {ADDRESS_WIDTH{1'b0}}}
                                       : {1'b0, len_reg};
    assign rec_last  = (wr_ptr_reg == len_m1);
    assign play_last = ({1'b0, rd_ptr_reg} == (stored_len_reg - SLEN_ONE));

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        len_next        = len_reg;
        stored_len_next = stored_len_reg;
        rec_done_next   = 1'b0;
        ram_we          = 1'b0;
        ram_rd_en       = 1'b0;
        ram_rd_addr     = rd_ptr_reg;

        if (stop) begin
            // Abort wins over everything; a half-finished recording is
            // discarded so it can never be played back.
            state_next = ST_IDLE;
            if (state_reg == ST_RECORD) begin
                stored_len_next = '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_next  = ST_RECORD;
                        len_next    = length;
                        wr_ptr_next = '0;
                    end else if (play_start && (stored_len_reg != '0)) begin
                        state_next  = ST_PRIME;
                        rd_ptr_next = '0;
                    end
                end

                ST_RECORD: begin
                    if (wr) begin
                        ram_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + ADDR_ONE;
                        if (rec_last) begin
                            stored_len_next = full_len;
                            rec_done_next   = 1'b1;
                            state_next      = ST_IDLE;
                        end
                    end
                end

                ST_PRIME: begin
                    // Fetch sample 0 so it is on play_data when PLAY begins.
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = '0;
                    state_next  = ST_PLAY;
                end

                ST_PLAY: begin
                    // Read ahead on accept so a held-high ready streams one
                    // sample per cycle; without accept, re-read the same
                    // address so play_data stays put.
                    ram_rd_en = 1'b1;
                    if (play_ready) begin
                        if (play_last) begin
                            if (loop) begin
                                rd_ptr_next = '0;
                                ram_rd_addr = '0;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end else begin
                            rd_ptr_next = rd_ptr_reg + ADDR_ONE;
                            ram_rd_addr = rd_ptr_reg + ADDR_ONE;
                        end
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            len_reg        <= '0;
            stored_len_reg <= '0;
            rec_done_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            len_reg        <= len_next;
            stored_len_reg <= stored_len_next;
            rec_done_reg   <= rec_done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sample RAM: one write port, one registered read port. Contents are not
    // reset; only the read register is cleared so play_data starts at zero.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr_reg] <= mic_signal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (ram_rd_en) begin
            rd_data_reg <= ram[ram_rd_addr];
        end
    end

    assign play_valid = (state_reg == ST_PLAY);
    assign play_data  = rd_data_reg;
    assign rec_done   = rec_done_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_sig_replay.sv
// -----------------------------------------------------------------------------
// tb_sig_replay
//
// Directed bench for sig_replay: reset state, short recording with write gaps,
// plain / backpressured / looping playback, stop in RECORD and PLAY, trigger
// priority, full-depth (length 0) recording and reset mid-playback.
// -----------------------------------------------------------------------------
module tb_sig_replay;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger;
    logic [AW-1:0] length;
    logic          wr;
    logic [DW-1:0] mic_signal;
    logic          play_start;
    logic          loop;
    logic          stop;
    logic          play_ready;
    logic          play_valid;
    logic [DW-1:0] play_data;
    logic          rec_done;
    logic [1:0]    state;

    always #5 clk = ~clk;

    sig_replay #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .length     (length),
        .wr         (wr),
        .mic_signal (mic_signal),
        .play_start (play_start),
        .loop       (loop),
        .stop       (stop),
        .play_ready (play_ready),
        .play_valid (play_valid),
        .play_data  (play_data),
        .rec_done   (rec_done),
        .state      (state)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0] exp_mem [0:511];
    bit            ready_pat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // play_start from IDLE: one PRIME cycle, then PLAY with sample 0 shown.
    task automatic start_play(input string tag);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check_val({tag, " prime state"}, 32'(state), 32'd2);
        check_val({tag, " prime valid"}, 32'(play_valid), 32'd0);
        tick();
        check_val({tag, " play state"}, 32'(state), 32'd3);
    endtask

    initial begin
        rst        = 1'b1;
        trigger    = 1'b0;
        length     = '0;
        wr         = 1'b0;
        mic_signal = '0;
        play_start = 1'b0;
        loop       = 1'b0;
        stop       = 1'b0;
        play_ready = 1'b0;
        exp_mem[0] = 8'h11;
        exp_mem[1] = 8'h22;
        exp_mem[2] = 8'h33;
        exp_mem[3] = 8'h44;

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        check_val("rst state", 32'(state), 32'd0);
        check_val("rst valid", 32'(play_valid), 32'd0);
        check_val("rst data", 32'(play_data), 32'd0);
        check_val("rst rec_done", 32'(rec_done), 32'd0);

        // ---------------- play with nothing stored ----------------
        play_start = 1'b1;
        play_ready = 1'b1;
        tick();
        play_start = 1'b0;
        check_val("empty play state", 32'(state), 32'd0);
        check_val("empty play valid", 32'(play_valid), 32'd0);

        // ---------------- record 4 samples with gaps ----------------
        length  = 9'd4;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_val("rec4 state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wr         = 1'b1;
            mic_signal = exp_mem[i];
            tick();
            wr = 1'b0;
            if (i < 3) begin
                check_val($sformatf("rec4 wr%0d rec_done", i), 32'(rec_done), 32'd0);
                tick();
                check_val($sformatf("rec4 gap%0d state", i), 32'(state), 32'd1);
            end
        end
        check_val("rec4 done pulse", 32'(rec_done), 32'd1);
        check_val("rec4 idle", 32'(state), 32'd0);
        tick();
        check_val("rec4 pulse end", 32'(rec_done), 32'd0);

        // ---------------- plain playback ----------------
        play_ready = 1'b1;
        start_play("p4");
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("p4 valid%0d", i), 32'(play_valid), 32'd1);
            check_val($sformatf("p4 data%0d", i), 32'(play_data), 32'(exp_mem[i]));
            tick();
        end
        check_val("p4 end valid", 32'(play_valid), 32'd0);
        check_val("p4 end state", 32'(state), 32'd0);

        // ---------------- backpressure ----------------
        play_ready = 1'b0;
        begin
            int idx;
            idx = 0;
            start_play("bp");
            for (int c = 0; c < 7; c++) begin
                play_ready = ready_pat[c];
                check_val($sformatf("bp valid c%0d", c), 32'(play_valid), 32'd1);
                check_val($sformatf("bp data c%0d", c), 32'(play_data), 32'(exp_mem[idx]));
                tick();
                if (ready_pat[c]) idx++;
            end
            check_val("bp accepted", 32'(idx), 32'd4);
            check_val("bp end valid", 32'(play_valid), 32'd0);
        end

        // ---------------- loop, then drop loop mid-pass ----------------
        loop       = 1'b1;
        play_ready = 1'b1;
        start_play("lp");
        for (int c = 0; c < 10; c++) begin
            check_val($sformatf("lp valid%0d", c), 32'(play_valid), 32'd1);
            check_val($sformatf("lp data%0d", c), 32'(play_data), 32'(exp_mem[c % 4]));
            tick();
        end
        loop = 1'b0;
        check_val("lp tail data0", 32'(play_data), 32'h33);
        tick();
        check_val("lp tail data1", 32'(play_data), 32'h44);
        check_val("lp tail valid1", 32'(play_valid), 32'd1);
        tick();
        check_val("lp end valid", 32'(play_valid), 32'd0);
        check_val("lp end state", 32'(state), 32'd0);

        // ---------------- stop during playback ----------------
        start_play("sp");
        tick();
        check_val("sp data", 32'(play_data), 32'h22);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("sp valid", 32'(play_valid), 32'd0);
        check_val("sp state", 32'(state), 32'd0);

        // ---------------- trigger beats play_start; stop after 2 writes ----------------
        length     = 9'd4;
        trigger    = 1'b1;
        play_start = 1'b1;
        tick();
        trigger    = 1'b0;
        play_start = 1'b0;
        check_val("prio state", 32'(state), 32'd1);
        for (int i = 0; i < 2; i++) begin
            wr         = 1'b1;
            mic_signal = 8'hA0 + 8'(i);
            tick();
        end
        wr   = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("abort state", 32'(state), 32'd0);
        check_val("abort rec_done", 32'(rec_done), 32'd0);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check_val("abort play state", 32'(state), 32'd0);
        check_val("abort play valid", 32'(play_valid), 32'd0);

        // ---------------- full-depth recording (length 0) ----------------
        length  = 9'd0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 512; i++) begin
            exp_mem[i] = 8'(i);
            wr         = 1'b1;
            mic_signal = 8'(i);
            tick();
            if (i == 510) begin
                check_val("full state before last", 32'(state), 32'd1);
                check_val("full rec_done before last", 32'(rec_done), 32'd0);
            end
        end
        wr = 1'b0;
        check_val("full rec_done", 32'(rec_done), 32'd1);
        check_val("full state", 32'(state), 32'd0);
        play_ready = 1'b1;
        start_play("fp");
        for (int i = 0; i < 512; i++) begin
            check_val($sformatf("fp data%0d", i), 32'(play_data), 32'(exp_mem[i]));
            tick();
        end
        check_val("fp end valid", 32'(play_valid), 32'd0);

        // ---------------- reset mid-playback ----------------
        start_play("rp");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rp state", 32'(state), 32'd0);
        check_val("rp valid", 32'(play_valid), 32'd0);
        check_val("rp data", 32'(play_data), 32'd0);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check_val("rp play ignored", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
